// File: rtl/smg_pkg.sv
// Shared constants for the seven-segment scanner: active-high glyphs (bit0=a .. bit6=g) and FSM states.
// The A-F hex glyphs exist only when SMG_HEX_EN is defined.
package smg_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } conv_state_e;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic logic [6:0] glyph(input logic [NIB_W-1:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
`ifdef SMG_HEX_EN
      4'd10:   g = GLYPH_A;
      4'd11:   g = GLYPH_B;
      4'd12:   g = GLYPH_C;
      4'd13:   g = GLYPH_D;
      4'd14:   g = GLYPH_E;
      4'd15:   g = GLYPH_F;
`endif
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/smg_bin2bcd.sv
// Serial double-dabble converter: start in IDLE, BIN_W shift cycles, done pulses for one LATCH cycle.
// state | meaning:  IDLE | waiting for start;  SHIFT | add-3 then shift one bit;  LATCH | bcd_o valid, done_o high
module smg_bin2bcd
  import smg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [BIN_W-1:0]            bin_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        ovf_o,
  output logic [NIB_W*(DIGITS+1)-1:0] bcd_o
);

  localparam int BCD_W = NIB_W * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned LIMIT = 64'(10 ** DIGITS);

  conv_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   adj;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    adj     = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          ovf_d   = (64'(bin_i) >= LIMIT);
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        for (int i = 0; i < DIGITS + 1; i++) begin
          if (adj[i*NIB_W +: NIB_W] >= NIB_W'(5))
            adj[i*NIB_W +: NIB_W] = adj[i*NIB_W +: NIB_W] + NIB_W'(3);
        end
        // The extra top nibble absorbs out-of-range values; its carry-out is dropped
        bcd_d = BCD_W'({adj, bin_q[BIN_W-1]});
        bin_d = bin_q << 1;
        if (cnt_q == '0) state_d = ST_LATCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_LATCH);
  assign ovf_o  = ovf_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/smg_scan_bcd.sv
// Binary-to-BCD seven-segment scanner with leading-zero blanking, decimal points and overflow dashes.
// Define SMG_HEX_EN to allow raw-hex loads (hex_mode_i) and the A-F glyphs.
module smg_scan_bcd
  import smg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter int SCAN_DIV    = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int WEI_ACT_LOW = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BIN_W-1:0]  val_in_i,
  input  logic              val_load_i,
  input  logic [DIGITS-1:0] dp_sel_i,
  input  logic              blank_lz_i,
  input  logic              hex_mode_i,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [6:0]        smg_duan_o,
  output logic [DIGITS-1:0] smg_wei_o,
  output logic              dp_o
);

  localparam int   DISP_W   = NIB_W * DIGITS;
  localparam int   IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int   SCAN_W   = $clog2(SCAN_DIV);
  localparam logic SEG_LOW  = (SEG_ACT_LOW != 0);
  localparam logic WEI_LOW  = (WEI_ACT_LOW != 0);

  logic                        conv_start, conv_busy, conv_done, conv_ovf;
  logic [NIB_W*(DIGITS+1)-1:0] conv_bcd;
  logic                        hex_load;

  logic [DISP_W-1:0] disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [6:0]        duan_q, duan_d;
  logic [DIGITS-1:0] wei_q, wei_d;
  logic              dp_q, dp_d;

  logic [DIGITS-1:0] blank;
  logic              lz_run;
  logic [NIB_W-1:0]  nib;
  logic [6:0]        seg;
  logic              dp_on;
  logic [DIGITS-1:0] wei_on;

`ifdef SMG_HEX_EN
  logic [DISP_W-1:0] hex_val;
  logic [NIB_W-1:0]  unused_bcd_top;
  assign hex_load       = val_load_i & hex_mode_i & ~conv_busy;
  assign unused_bcd_top = conv_bcd[NIB_W*(DIGITS+1)-1 -: NIB_W];
  if (BIN_W >= DISP_W) begin : g_hex_trunc
    assign hex_val = val_in_i[DISP_W-1:0];
  end else begin : g_hex_pad
    assign hex_val = {{(DISP_W-BIN_W){1'b0}}, val_in_i};
  end
`else
  logic [NIB_W:0] unused_bits;
  assign hex_load    = 1'b0;
  assign unused_bits = {conv_bcd[NIB_W*(DIGITS+1)-1 -: NIB_W], hex_mode_i};
`endif

  assign conv_start = val_load_i & ~hex_load;

  smg_bin2bcd #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_bin2bcd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (conv_start),
    .bin_i   (val_in_i),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .ovf_o   (conv_ovf),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (conv_done) begin
      disp_d = conv_bcd[DISP_W-1:0];
      ovf_d  = conv_ovf;
    end
`ifdef SMG_HEX_EN
    else if (hex_load) begin
      disp_d = hex_val;
      ovf_d  = 1'b0;
    end
`endif
  end

  // Leading-zero run from the MSB; a set dp bit ends the run so "0." stays visible
  always_comb begin
    blank  = '0;
    lz_run = blank_lz_i;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lz_run && (disp_q[i*NIB_W +: NIB_W] == '0) && !dp_sel_i[i]) blank[i] = 1'b1;
      else                                                             lz_run   = 1'b0;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    nib = disp_q[idx_d*NIB_W +: NIB_W];
    if (ovf_q)             seg = GLYPH_DASH;
    else if (blank[idx_d]) seg = GLYPH_BLANK;
    else                   seg = glyph(nib);
    dp_on         = dp_sel_i[idx_d] & (ovf_q | ~blank[idx_d]);
    wei_on        = '0;
    wei_on[idx_d] = 1'b1;
    duan_d = seg ^ {7{SEG_LOW}};
    dp_d   = dp_on ^ SEG_LOW;
    wei_d  = wei_on ^ {DIGITS{WEI_LOW}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      duan_q     <= {7{SEG_LOW}};
      dp_q       <= SEG_LOW;
      wei_q      <= {DIGITS{WEI_LOW}};
    end else begin
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      duan_q     <= duan_d;
      dp_q       <= dp_d;
      wei_q      <= wei_d;
    end
  end

  assign busy_o     = conv_busy;
  assign ovf_o      = ovf_q;
  assign smg_duan_o = duan_q;
  assign smg_wei_o  = wei_q;
  assign dp_o       = dp_q;

endmodule

// File: tb/tb_smg_scan_bcd.sv
// Scoreboard bench for smg_scan_bcd (DIGITS=4, BIN_W=14, SCAN_DIV=4, active-low pins).
module tb_smg_scan_bcd;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] val_in;
  logic        val_load;
  logic [3:0]  dp_sel;
  logic        blank_lz;
  logic        hex_mode;
  logic        busy, ovf, dp;
  logic [6:0]  duan;
  logic [3:0]  wei;

  always #5 clk = ~clk;

  smg_scan_bcd #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .SEG_ACT_LOW(1), .WEI_ACT_LOW(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .val_in_i(val_in), .val_load_i(val_load), .dp_sel_i(dp_sel),
    .blank_lz_i(blank_lz), .hex_mode_i(hex_mode), .busy_o(busy), .ovf_o(ovf),
    .smg_duan_o(duan), .smg_wei_o(wei), .dp_o(dp)
  );

  typedef struct {
    logic [13:0] v;
    logic        hex;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Active-low segment codes for 0-9, A-F
  localparam logic [6:0] SEG_LO [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input exp_t e, input int d);
    logic [3:0] nib [DIGITS];
    logic       blanked;
    logic [6:0] seg;
    logic       dpv;
    int         val, pw;
    val = int'(e.v);
    pw  = 1;
    for (int j = 0; j < DIGITS; j++) begin
      int n;
      n      = e.hex ? ((val >> (4*j)) & 15) : ((val / pw) % 10);
      nib[j] = n[3:0];
      pw     = pw * 10;
    end
    blanked = blank_lz && (d != 0);
    for (int j = d; j < DIGITS; j++)
      if (nib[j] != 4'd0 || dp_sel[j]) blanked = 1'b0;
    if (e.ovf) begin
      seg = 7'h3F;
      dpv = ~dp_sel[d];
    end else if (blanked) begin
      seg = 7'h7F;
      dpv = 1'b1;
    end else begin
      seg = SEG_LO[nib[d]];
      dpv = ~dp_sel[d];
    end
    return {dpv, seg};
  endfunction

  function automatic int active_digit();
    for (int d = 0; d < DIGITS; d++)
      if (wei[d] == 1'b0) return d;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_current(input string tag);
    int d;
    d = active_digit();
    chk({tag, "_active"}, (d >= 0), 1);
    if (exp_q.size() > 0 && d >= 0) chk(tag, {dp, duan}, model(exp_q[0], d));
  endtask

  task automatic scan_check(input string tag);
    exp_t e;
    int   d;
    chk({tag, "_sb"}, exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk({tag, "_ovf"}, ovf, e.ovf);
    for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
      d = active_digit();
      chk({tag, "_onehot"}, $countones(~wei), 1);
      if (d >= 0) chk({tag, "_dig"}, {dp, duan}, model(e, d));
      tick();
    end
  endtask

  task automatic strobe(input logic [13:0] v, input logic hx);
    val_in   = v;
    hex_mode = hx;
    val_load = 1'b1;
    tick();
    val_load = 1'b0;
    hex_mode = 1'b0;
  endtask

  task automatic push_exp(input int v, input logic hx);
    exp_t e;
    e.v = 14'(v);
`ifdef SMG_HEX_EN
    e.hex = hx;
`else
    e.hex = 1'b0;
`endif
    e.ovf = !e.hex && (v >= 10000);
    exp_q.push_back(e);
  endtask

  task automatic load(input string tag, input int v, input logic hx);
    push_exp(v, hx);
    strobe(14'(v), hx);
    if (exp_q[exp_q.size()-1].hex) begin
      chk({tag, "_hex_busy"}, busy, 0);
      tick();
      check_current({tag, "_hex_lat"});
      chk({tag, "_hex_busy2"}, busy, 0);
    end else begin
      for (int k = 0; k < BIN_W + 1; k++) begin
        chk({tag, "_busy_hi"}, busy, 1);
        tick();
      end
      chk({tag, "_busy_lo"}, busy, 0);
      tick();
      check_current({tag, "_lat"});
    end
  endtask

  task automatic runs(input string tag);
    logic [3:0] prev;
    int         n;
    prev = wei;
    n    = 0;
    while (wei == prev && n < 20) begin tick(); n++; end
    chk({tag, "_sync"}, (n < 20), 1);
    for (int r = 0; r < DIGITS; r++) begin
      chk({tag, "_order"}, wei, {prev[2:0], prev[3]});
      prev = wei;
      n    = 0;
      while (wei == prev && n < 20) begin tick(); n++; end
      chk({tag, "_len"}, n, SCAN_DIV);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    val_in   = '0;
    val_load = 1'b0;
    dp_sel   = 4'b0000;
    blank_lz = 1'b1;
    hex_mode = 1'b0;
    tick();
    tick();
    chk("rst_wei",  wei,  4'b1111);
    chk("rst_duan", duan, 7'h7F);
    chk("rst_dp",   dp,   1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf",  ovf,  0);
    rst = 1'b0;
    tick();
    chk("rst_first_wei",  wei,  4'b1110);
    chk("rst_first_duan", duan, 7'h40);
    push_exp(0, 1'b0);
    scan_check("rst_scan");

    blank_lz = 1'b0;
    load("t2", 1234, 1'b0);
    scan_check("t2");
    runs("t2");

    blank_lz = 1'b1;
    dp_sel   = 4'b0100;
    load("t3", 7, 1'b0);
    scan_check("t3");

    dp_sel = 4'b0010;
    load("t4_ovf", 10000, 1'b0);
    scan_check("t4_ovf");
    dp_sel = 4'b0000;
    load("t4_9999", 9999, 1'b0);
    scan_check("t4_9999");

    blank_lz = 1'b0;
    push_exp(300, 1'b0);
    strobe(14'd300, 1'b0);
    repeat (4) tick();
    strobe(14'd55, 1'b0);
    chk("t5_busy_mid", busy, 1);
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk("t5_idle", (n < 40), 1);
    tick();
    scan_check("t5_ign");

    strobe(14'd1234, 1'b0);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_busy", busy, 0);
    push_exp(0, 1'b0);
    tick();
    scan_check("t5_rst");

    load("t6", 14'h3A5F, 1'b1);
    scan_check("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
